spi_ad_cfg_master: RTL and testbench

- Parametrised 3-wire SPI master for ADC/AFE register configuration.
- Runs from the system clock and generates SCLK internally with a programmable divider.
- Drives one of N_CS chip selects. Supports 1–4 byte write/read bursts using the standard instruction word {R/W, W1, W0, address}.
- Sits between the configuration sequencer (Start/Busy/Done handshake) and the converter SPI pins.

---
 rtl/spi_ad_cfg_master.sv | 196 +++++++++++++++++++
 tb/tb_spi_ad_cfg_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ad_cfg_master.sv
// ---------------------------------------------------------------------------
// spi_ad_cfg_master
//   3-wire (shared SDIO) SPI master for ADC/AFE register configuration.
//   A request {RW, Len, Addr, CS_Sel, Wr_Data} is latched on Start while idle,
//   then shifted out MSB first as the instruction word {RW, Len[1:0], Addr}
//   followed by 1..4 data bytes. Reads release SDIO after the instruction and
//   capture the slave's bytes on SCLK rising edges. SCLK is mode 0 (idle low)
//   and is produced by a divider running from CLK.
//
// Ports
//   CLK, RST_n      system clock, asynchronous active-low reset
//   Start           one-cycle request (ignored while Busy)
//   RW, Len         1=read / 0=write; byte count minus one
//   Addr, CS_Sel    register address; chip-select index
//   Wr_Data         write payload, right-aligned
//   Rd_Data         read payload, right-aligned, updated when a read completes
//   Busy, Done, Err transfer in progress; completion pulse; reject pulse
//   SPI_SCLK        serial clock, idle low
//   SPI_CS_n        active-low chip selects, idle all high
//   SPI_SDIO        bidirectional serial data, Z when not driven
// ---------------------------------------------------------------------------
module spi_ad_cfg_master #(
    parameter int ADDR_W   = 13,
    parameter int N_CS     = 4,
    parameter int HALF_DIV = 2,
    parameter int GAP_CYC  = 8,
    localparam int SEL_W   = (N_CS > 1) ? $clog2(N_CS) : 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Start,
    input  logic              RW,
    input  logic [1:0]        Len,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [SEL_W-1:0]  CS_Sel,
    input  logic [31:0]       Wr_Data,
    output logic [31:0]       Rd_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic              SPI_SCLK,
    output logic [N_CS-1:0]   SPI_CS_n,
    inout  wire               SPI_SDIO
);

    localparam int CMD_W   = ADDR_W + 3;
    localparam int TX_W    = CMD_W + 32;
    localparam int BIT_W   = $clog2(TX_W);
    localparam int GAP_LEN = GAP_CYC * 2 * HALF_DIV;
    localparam int CNT_MAX = (GAP_LEN > HALF_DIV) ? GAP_LEN : HALF_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_REJECT = 3'd5;

    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [BIT_W-1:0] bit_reg;
    logic [BIT_W-1:0] last_bit_reg;
    logic [TX_W-1:0]  tx_reg;
    logic [31:0]      rx_reg;
    logic [31:0]      rd_data_reg;
    logic             rw_reg;
    logic             err_reg;
    logic             sclk_reg;
    logic             oe_reg;
    logic [N_CS-1:0]  cs_n_reg;

    logic [N_CS-1:0]  sel_onehot;
    logic             sel_valid;
    logic             accept;
    logic             half_end;

    // One-hot decode of the requested chip select.
    for (genvar gi = 0; gi < N_CS; gi++) begin : g_sel
        assign sel_onehot[gi] = (CS_Sel == SEL_W'(gi));
    end

    assign sel_valid = (32'(CS_Sel) < N_CS);
    assign accept    = Start && !Busy;
    assign half_end  = (cnt_reg == CNT_W'(HALF_DIV - 1));

    assign Busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign Done     = (state_reg == S_DONE);
    assign Err      = (state_reg == S_DONE) && err_reg;
    assign Rd_Data  = rd_data_reg;
    assign SPI_SCLK = sclk_reg;
    assign SPI_CS_n = cs_n_reg;
    assign SPI_SDIO = oe_reg ? tx_reg[TX_W-1] : 1'bz;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            last_bit_reg <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rd_data_reg  <= '0;
            rw_reg       <= 1'b0;
            err_reg      <= 1'b0;
            sclk_reg     <= 1'b0;
            oe_reg       <= 1'b0;
            cs_n_reg     <= '1;
        end else begin
            case (state_reg)
                S_SHIFT: begin
                    // Read samples are taken in the cycle SCLK is first high,
                    // i.e. right after the rising edge; instruction-phase
                    // samples are skipped so unused upper bits stay zero.
                    if (rw_reg && sclk_reg && (cnt_reg == '0) &&
                        (bit_reg >= BIT_W'(CMD_W))) begin
                        rx_reg <= {rx_reg[30:0], SPI_SDIO};
                    end
                    if (half_end) begin
                        cnt_reg <= '0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit or finish.
                            sclk_reg <= 1'b0;
                            if (bit_reg == last_bit_reg) begin
                                state_reg <= S_HOLD;
                                oe_reg    <= 1'b0;
                            end else begin
                                bit_reg <= bit_reg + 1'b1;
                                tx_reg  <= tx_reg << 1;
                                if (rw_reg && (bit_reg == BIT_W'(CMD_W - 1))) begin
                                    oe_reg <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (half_end) begin
                        cnt_reg   <= '0;
                        cs_n_reg  <= '1;
                        state_reg <= S_GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt_reg == CNT_W'(GAP_LEN - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_DONE;
                        if (rw_reg) begin
                            rd_data_reg <= rx_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_REJECT: begin
                    state_reg <= S_DONE;
                end

                default: begin
                    // IDLE and DONE: a new request may be taken here, so a
                    // back-to-back Start in the Done cycle is not lost.
                    if (accept) begin
                        rw_reg       <= RW;
                        tx_reg       <= {RW, Len, Addr, Wr_Data << {~Len, 3'b000}};
                        last_bit_reg <= BIT_W'(CMD_W + 7) + BIT_W'({Len, 3'b000});
                        bit_reg      <= '0;
                        cnt_reg      <= '0;
                        rx_reg       <= '0;
                        sclk_reg     <= 1'b0;
                        if (sel_valid) begin
                            err_reg   <= 1'b0;
                            oe_reg    <= 1'b1;
                            cs_n_reg  <= ~sel_onehot;
                            state_reg <= S_SHIFT;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= S_REJECT;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ad_cfg_master.sv
// ---------------------------------------------------------------------------
// tb_spi_ad_cfg_master
//   Directed bench for spi_ad_cfg_master. Three instances:
//     0: HALF_DIV=2, N_CS=4 (default build)
//     1: HALF_DIV=1, N_CS=3 (fast divider, and a select range with spare codes)
//     2: HALF_DIV=5, N_CS=4 (slow divider)
//   Each instance has a slave model that drives one read byte on SCLK falls
//   and a monitor that records pin timing relative to the Start cycle.
// ---------------------------------------------------------------------------
module tb_spi_ad_cfg_master;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic        rw_in = 1'b0;
    logic [1:0]  len_in = '0;
    logic [12:0] addr_in = '0;
    logic [1:0]  sel_in = '0;
    logic [31:0] wd_in = '0;
    logic [7:0]  slave_byte = '0;

    wire  [2:0]  done_v;
    wire  [2:0]  busy_v;
    wire  [3:0]  exp_cs = ~(4'b0001 << sel_in);

    int cyc = 0;
    int t0 = 0;
    int txn_id = 0;
    int txn_no = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int HD  = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);
        localparam int NCS = (gi == 1) ? 3 : 4;

        wire        sdio_w;
        wire        sclk_w;
        wire [3:0]  cs_n_w;
        wire        busy_w;
        wire        done_w;
        wire        err_w;
        wire [31:0] rd_w;

        spi_ad_cfg_master #(
            .ADDR_W   (13),
            .N_CS     (NCS),
            .HALF_DIV (HD),
            .GAP_CYC  (8)
        ) u_dut (
            .CLK      (CLK),
            .RST_n    (RST_n),
            .Start    (start_v[gi]),
            .RW       (rw_in),
            .Len      (len_in),
            .Addr     (addr_in),
            .CS_Sel   (sel_in),
            .Wr_Data  (wd_in),
            .Rd_Data  (rd_w),
            .Busy     (busy_w),
            .Done     (done_w),
            .Err      (err_w),
            .SPI_SCLK (sclk_w),
            .SPI_CS_n (cs_n_w[NCS-1:0]),
            .SPI_SDIO (sdio_w)
        );

        if (NCS == 3) begin : g_pad
            assign cs_n_w[3] = 1'b1;
        end

        assign done_v[gi] = done_w;
        assign busy_v[gi] = busy_w;

        // Slave drive and pin monitor.
        logic        slv_oe = 1'b0;
        logic        slv_bit = 1'b0;
        logic        sclk_prev = 1'b0;
        logic [47:0] mosi = '0;
        logic [3:0]  cs_first = 4'hF;
        int seen_id = -1;
        int rises = 0, falls = 0, done_cnt = 0, err_cnt = 0, other_cs = 0;
        int cs_low_cyc = -1, cs_high_cyc = -1, z_cyc = -1, done_cyc = -1;
        int rise1 = -1, rise2 = -1, fall1 = -1;

        assign sdio_w = slv_oe ? slv_bit : 1'bz;

        always @(negedge CLK) begin
            if (txn_id != seen_id) begin
                seen_id = txn_id;
                rises = 0; falls = 0; done_cnt = 0; err_cnt = 0; other_cs = 0;
                cs_low_cyc = -1; cs_high_cyc = -1; z_cyc = -1; done_cyc = -1;
                rise1 = -1; rise2 = -1; fall1 = -1;
                mosi = '0; cs_first = 4'hF; slv_oe = 1'b0;
            end
            if (cs_n_w != 4'hF) begin
                if (cs_low_cyc < 0) begin
                    cs_low_cyc = cyc;
                    cs_first = cs_n_w;
                end
                if (cs_n_w != exp_cs) other_cs++;
                if (z_cyc < 0 && sdio_w === 1'bz) z_cyc = cyc;
            end else begin
                if (cs_low_cyc >= 0 && cs_high_cyc < 0) cs_high_cyc = cyc;
                slv_oe = 1'b0;
            end
            if (sclk_w && !sclk_prev) begin
                rises++;
                mosi = {mosi[46:0], sdio_w};
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) rise2 = cyc;
            end
            if (!sclk_w && sclk_prev) begin
                falls++;
                if (fall1 < 0) fall1 = cyc;
                if (rw_in && falls >= 16 && falls < 24) begin
                    slv_oe = 1'b1;
                    slv_bit = slave_byte[23 - falls];
                end else begin
                    slv_oe = 1'b0;
                end
            end
            if (done_w) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (err_w) err_cnt++;
            end
            sclk_prev = sclk_w;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a request at a falling edge; the following rising edge is the
    // Start cycle T0. Returns at the falling edge inside T0+1.
    task automatic start_txn(input int idx, input logic rw, input logic [1:0] len,
                             input logic [12:0] addr, input logic [1:0] sel,
                             input logic [31:0] wd);
        @(negedge CLK);
        rw_in = rw; len_in = len; addr_in = addr; sel_in = sel; wd_in = wd;
        start_v[idx] = 1'b1;
        t0 = cyc;
        txn_id++;
        @(negedge CLK);
        start_v[idx] = 1'b0;
    endtask

    // Returns the Done cycle relative to T0, or -1 if the budget expired.
    task automatic wait_done(input int idx, input int budget, output int rel);
        rel = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_v[idx]) begin
                rel = cyc - t0;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic log_txn(input int idx, input int rel);
        txn_no++;
        $display("txn %0d: inst=%0d rw=%0d len=%0d addr=0x%04h sel=%0d wd=0x%08h done@T0+%0d",
                 txn_no, idx, rw_in, len_in, addr_in, sel_in, wd_in, rel);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;

        // ---------------- reset state ----------------
        @(negedge CLK);
        check_val("rst_busy",  busy_v[0], 1'b0);
        check_val("rst_done",  done_v[0], 1'b0);
        check_val("rst_err",   g_dut[0].err_w, 1'b0);
        check_val("rst_sclk",  g_dut[0].sclk_w, 1'b0);
        check_val("rst_cs",    g_dut[0].cs_n_w, 4'hF);
        check_val("rst_sdio_z", (g_dut[0].sdio_w === 1'bz), 1'b1);
        check_val("rst_rd",    g_dut[0].rd_w, 32'h0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);

        // ---------------- 1-byte write ----------------
        start_txn(0, 1'b0, 2'd0, 13'h0014, 2'd1, 32'h0000_00A5);
        wait_done(0, 400, rel);
        log_txn(0, rel);
        check_val("wr1_done_cyc", rel, 131);
        check_val("wr1_busy_at_done", busy_v[0], 1'b0);
        check_val("wr1_err", g_dut[0].err_w, 1'b0);
        check_val("wr1_rd_unchanged", g_dut[0].rd_w, 32'h0);
        @(negedge CLK);
        check_val("wr1_mosi", g_dut[0].mosi[23:0], 24'h0014A5);
        check_val("wr1_rises", g_dut[0].rises, 24);
        check_val("wr1_cs_low", g_dut[0].cs_low_cyc - t0, 1);
        check_val("wr1_cs_val", g_dut[0].cs_first, 4'b1101);
        check_val("wr1_cs_high", g_dut[0].cs_high_cyc - t0, 99);
        check_val("wr1_sdio_z", g_dut[0].z_cyc - t0, 97);
        check_val("wr1_other_cs", g_dut[0].other_cs, 0);
        check_val("wr1_first_rise", g_dut[0].rise1 - t0, 3);

        // ---------------- 1-byte read ----------------
        slave_byte = 8'h3C;
        start_txn(0, 1'b1, 2'd0, 13'h0001, 2'd0, 32'h0);
        wait_done(0, 400, rel);
        log_txn(0, rel);
        check_val("rd1_done_cyc", rel, 131);
        check_val("rd1_data", g_dut[0].rd_w, 32'h0000_003C);
        @(negedge CLK);
        check_val("rd1_instr", g_dut[0].mosi[23:8], 16'h8001);
        check_val("rd1_sdio_z", g_dut[0].z_cyc - t0, 65);
        check_val("rd1_cs_val", g_dut[0].cs_first, 4'b1110);

        // ---------------- 3-byte write ----------------
        start_txn(0, 1'b0, 2'd2, 13'h0100, 2'd2, 32'h0012_3456);
        wait_done(0, 400, rel);
        log_txn(0, rel);
        check_val("wr3_done_cyc", rel, 195);
        check_val("wr3_rd_unchanged", g_dut[0].rd_w, 32'h0000_003C);
        @(negedge CLK);
        check_val("wr3_mosi", g_dut[0].mosi[39:0], 40'h41_0012_3456);
        check_val("wr3_rises", g_dut[0].rises, 40);
        check_val("wr3_cs_high", g_dut[0].cs_high_cyc - t0, 163);
        check_val("wr3_other_cs", g_dut[0].other_cs, 0);

        // ---------------- 4-byte write ----------------
        start_txn(0, 1'b0, 2'd3, 13'h1ABC, 2'd3, 32'hDEAD_BEEF);
        wait_done(0, 400, rel);
        log_txn(0, rel);
        check_val("wr4_done_cyc", rel, 227);
        @(negedge CLK);
        check_val("wr4_mosi", g_dut[0].mosi, 48'h7ABC_DEAD_BEEF);
        check_val("wr4_rises", g_dut[0].rises, 48);
        check_val("wr4_cs_high", g_dut[0].cs_high_cyc - t0, 195);

        // ---------------- Start while busy is ignored ----------------
        start_txn(0, 1'b0, 2'd0, 13'h0055, 2'd1, 32'h0000_0033);
        repeat (20) @(negedge CLK);
        addr_in = 13'h1FFF; wd_in = 32'h0000_00FF;
        start_v[0] = 1'b1;
        @(negedge CLK);
        start_v[0] = 1'b0;
        wait_done(0, 400, rel);
        log_txn(0, rel);
        check_val("busy_done_cyc", rel, 131);
        repeat (160) @(negedge CLK);
        check_val("busy_done_cnt", g_dut[0].done_cnt, 1);
        check_val("busy_mosi", g_dut[0].mosi[23:0], 24'h005533);
        check_val("busy_rises", g_dut[0].rises, 24);

        // ---------------- rejected chip select ----------------
        start_txn(1, 1'b0, 2'd0, 13'h0010, 2'd3, 32'h0000_0011);
        check_val("rej_busy_t1", busy_v[1], 1'b1);
        wait_done(1, 20, rel);
        log_txn(1, rel);
        check_val("rej_done_cyc", rel, 2);
        check_val("rej_err", g_dut[1].err_w, 1'b1);
        check_val("rej_busy_at_done", busy_v[1], 1'b0);
        repeat (10) @(negedge CLK);
        check_val("rej_err_cnt", g_dut[1].err_cnt, 1);
        check_val("rej_rises", g_dut[1].rises, 0);
        check_val("rej_no_cs", g_dut[1].cs_low_cyc, -1);

        // ---------------- reset mid-transfer ----------------
        start_txn(0, 1'b0, 2'd1, 13'h00AA, 2'd3, 32'h0000_1234);
        while (cyc < t0 + 43) @(negedge CLK);
        check_val("mid_sclk_high", g_dut[0].sclk_w, 1'b1);
        #1 RST_n = 1'b0;
        #1;
        check_val("mid_rst_cs", g_dut[0].cs_n_w, 4'hF);
        check_val("mid_rst_sclk", g_dut[0].sclk_w, 1'b0);
        check_val("mid_rst_sdio_z", (g_dut[0].sdio_w === 1'bz), 1'b1);
        check_val("mid_rst_busy", busy_v[0], 1'b0);
        check_val("mid_rst_rd", g_dut[0].rd_w, 32'h0);
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        repeat (150) @(negedge CLK);
        $display("txn %0d: inst=0 reset at bit 10, done_cnt=%0d", txn_no + 1, g_dut[0].done_cnt);
        txn_no++;
        check_val("mid_rst_no_done", g_dut[0].done_cnt, 0);

        start_txn(0, 1'b0, 2'd0, 13'h0014, 2'd1, 32'h0000_00A5);
        wait_done(0, 400, rel);
        log_txn(0, rel);
        check_val("post_rst_done_cyc", rel, 131);
        @(negedge CLK);
        check_val("post_rst_mosi", g_dut[0].mosi[23:0], 24'h0014A5);

        // ---------------- divider sweep: HALF_DIV=1 ----------------
        slave_byte = 8'h96;
        start_txn(1, 1'b1, 2'd0, 13'h0002, 2'd0, 32'h0);
        wait_done(1, 400, rel);
        log_txn(1, rel);
        check_val("hd1_done_cyc", rel, 66);
        check_val("hd1_rd", g_dut[1].rd_w, 32'h0000_0096);
        @(negedge CLK);
        check_val("hd1_period", g_dut[1].rise2 - g_dut[1].rise1, 2);
        check_val("hd1_high", g_dut[1].fall1 - g_dut[1].rise1, 1);
        check_val("hd1_rises", g_dut[1].rises, 24);
        check_val("hd1_sdio_z", g_dut[1].z_cyc - t0, 33);

        // ---------------- divider sweep: HALF_DIV=5 ----------------
        slave_byte = 8'h5A;
        start_txn(2, 1'b1, 2'd0, 13'h0003, 2'd2, 32'h0);
        wait_done(2, 800, rel);
        log_txn(2, rel);
        check_val("hd5_done_cyc", rel, 326);
        check_val("hd5_rd", g_dut[2].rd_w, 32'h0000_005A);
        @(negedge CLK);
        check_val("hd5_period", g_dut[2].rise2 - g_dut[2].rise1, 10);
        check_val("hd5_high", g_dut[2].fall1 - g_dut[2].rise1, 5);
        check_val("hd5_sdio_z", g_dut[2].z_cyc - t0, 161);
        check_val("hd5_cs_high", g_dut[2].cs_high_cyc - t0, 246);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
